alu_sequencer: RTL and testbench

Control-and-register stage wrapped around the 8-bit ALU of the s_proc_v1 core. It accepts one 16-bit instruction at a time over a valid/ready handshake and holds a 4 x 8-bit register file plus carry and zero flags. It drives the ALU's `a`, `b` and 5-bit `alu` select inputs, consumes `dout` and `carry`, writes the result back, and reports completion with a one-cycle pulse.

---
 rtl/alu_sequencer.sv | 178 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Sequencer around the 8-bit s_proc_v1 ALU: accepts one instruction per handshake,
// drives the ALU from a 4 x 8-bit register file and writes the result back with flags.
module alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [4:0]  alu_op,
    input  logic [7:0]  alu_dout,
    input  logic        alu_carry,
    output logic        res_valid,
    output logic [7:0]  res_data,
    output logic        flag_c,
    output logic        flag_z,
    input  logic [1:0]  dbg_sel,
    output logic [7:0]  dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_NOP  = 3'd2;
    localparam logic [2:0] OP_MOV  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_INC  = 3'd5;
    localparam logic [2:0] OP_LDI  = 3'd6;
    localparam logic [2:0] OP_ADDI = 3'd7;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_AND  = 5'b00001;
    localparam logic [4:0] ALU_PASS = 5'b00010;
    localparam logic [4:0] ALU_MOVB = 5'b00011;
    localparam logic [4:0] ALU_SUB  = 5'b01100;
    localparam logic [4:0] ALU_INC  = 5'b10100;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_ir;
    logic [7:0]  r_regs [4];
    logic        r_flag_c;
    logic        r_flag_z;
    logic [7:0]  r_res_data;

    logic [2:0]  w_opcode;
    logic [1:0]  w_rd;
    logic [1:0]  w_rs;
    logic [7:0]  w_imm;
    logic        w_load_c;
    logic        w_load_z;
    logic        w_unused_reserved;

    assign w_opcode          = r_ir[15:13];
    assign w_rd              = r_ir[12:11];
    assign w_rs              = r_ir[10:9];
    assign w_imm             = r_ir[7:0];
    assign w_unused_reserved = r_ir[8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The ALU is only driven with real operands during EXEC; elsewhere it sees a harmless pass of zero.
    always_comb begin
        w_next_state = r_state;
        alu_a        = 8'h00;
        alu_b        = 8'h00;
        alu_op       = ALU_PASS;
        w_load_c     = 1'b0;
        w_load_z     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (instr_valid) begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next_state = S_DONE;
                w_load_z     = 1'b1;
                case (w_opcode)
                    OP_ADD: begin
                        alu_a    = r_regs[w_rd];
                        alu_b    = r_regs[w_rs];
                        alu_op   = ALU_ADD;
                        w_load_c = 1'b1;
                    end
                    OP_AND: begin
                        alu_a  = r_regs[w_rd];
                        alu_b  = r_regs[w_rs];
                        alu_op = ALU_AND;
                    end
                    OP_NOP: begin
                        alu_a    = r_regs[w_rd];
                        alu_op   = ALU_PASS;
                        w_load_z = 1'b0;
                    end
                    OP_MOV: begin
                        alu_b  = r_regs[w_rs];
                        alu_op = ALU_MOVB;
                    end
                    OP_SUB: begin
                        alu_a    = r_regs[w_rd];
                        alu_b    = r_regs[w_rs];
                        alu_op   = ALU_SUB;
                        w_load_c = 1'b1;
                    end
                    OP_INC: begin
                        alu_a    = r_regs[w_rd];
                        alu_op   = ALU_INC;
                        w_load_c = 1'b1;
                    end
                    OP_LDI: begin
                        alu_b  = w_imm;
                        alu_op = ALU_MOVB;
                    end
                    default: begin
                        alu_a    = r_regs[w_rd];
                        alu_b    = w_imm;
                        alu_op   = ALU_ADD;
                        w_load_c = 1'b1;
                    end
                endcase
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Write-back happens on the EXEC->DONE edge, so a reset during EXEC drops the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir       <= 16'h0000;
            r_flag_c   <= 1'b0;
            r_flag_z   <= 1'b0;
            r_res_data <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else begin
            if (r_state == S_IDLE && instr_valid) begin
                r_ir <= instr;
            end
            if (r_state == S_EXEC) begin
                r_regs[w_rd] <= alu_dout;
                r_res_data   <= alu_dout;
                if (w_load_c) begin
                    r_flag_c <= alu_carry;
                end
                if (w_load_z) begin
                    r_flag_z <= (alu_dout == 8'h00);
                end
            end
        end
    end

    assign instr_ready = (r_state == S_IDLE);
    assign res_valid   = (r_state == S_DONE);
    assign res_data    = r_res_data;
    assign flag_c      = r_flag_c;
    assign flag_z      = r_flag_z;
    assign dbg_data    = r_regs[dbg_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU stands in for the core's ALU,
// a register-file model predicts every result, and a vector table covers the directed cases.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [4:0]  alu_op;
    logic [7:0]  alu_dout;
    logic        alu_carry;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        flag_c;
    logic        flag_z;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;

    logic [7:0] mRegs [4];
    logic       mC;
    logic       mZ;
    logic [7:0] mRes;

    logic [7:0] gotRes;
    logic       gotC;
    logic       gotZ;

    typedef struct {
        logic [15:0] ins;
        logic [7:0]  expRes;
        logic        expC;
        logic        expZ;
    } vec_t;

    vec_t vecs [15];

    alu_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_dout    (alu_dout),
        .alu_carry   (alu_carry),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .flag_c      (flag_c),
        .flag_z      (flag_z),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Stand-in for the core's ALU; logic ops return a data-dependent carry so stray flag loads show up.
    always_comb begin
        alu_dout  = 8'h00;
        alu_carry = 1'b0;
        case (alu_op)
            5'b00000: {alu_carry, alu_dout} = {1'b0, alu_a} + {1'b0, alu_b};
            5'b00001: begin
                alu_dout  = alu_a & alu_b;
                alu_carry = ^{alu_a, alu_b};
            end
            5'b00010, 5'b00011: begin
                alu_dout  = alu_a | alu_b;
                alu_carry = ~^{alu_a, alu_b};
            end
            5'b01100: {alu_carry, alu_dout} = {1'b0, alu_a} - {1'b0, alu_b};
            5'b10100: {alu_carry, alu_dout} = {1'b0, alu_a} + 9'd1;
            default:  alu_dout = 8'hEE;
        endcase
    end

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, 1'b0, imm};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) mRegs[i] = 8'h00;
        mC   = 1'b0;
        mZ   = 1'b0;
        mRes = 8'h00;
    endtask

    // Expected ALU drive for an instruction, taken straight from the decode table.
    function automatic void expDrive(input logic [15:0] ins, output logic [7:0] a,
                                     output logic [7:0] b, output logic [4:0] op);
        logic [7:0] x = mRegs[ins[12:11]];
        logic [7:0] y = mRegs[ins[10:9]];
        a = 8'h00;
        b = 8'h00;
        op = 5'b00010;
        case (ins[15:13])
            3'd0: begin a = x; b = y;       op = 5'b00000; end
            3'd1: begin a = x; b = y;       op = 5'b00001; end
            3'd2: begin a = x;              op = 5'b00010; end
            3'd3: begin b = y;              op = 5'b00011; end
            3'd4: begin a = x; b = y;       op = 5'b01100; end
            3'd5: begin a = x;              op = 5'b10100; end
            3'd6: begin b = ins[7:0];       op = 5'b00011; end
            default: begin a = x; b = ins[7:0]; op = 5'b00000; end
        endcase
    endfunction

    // Architectural effect of one instruction expressed as plain arithmetic.
    task automatic modelExec(input logic [15:0] ins);
        logic [7:0] x = mRegs[ins[12:11]];
        logic [7:0] y = mRegs[ins[10:9]];
        logic [7:0] imm = ins[7:0];
        int         s;
        logic [7:0] r;
        case (ins[15:13])
            3'd0: begin s = int'(x) + int'(y);   r = s[7:0]; mC = (s > 255); end
            3'd1: r = x & y;
            3'd2: r = x;
            3'd3: r = y;
            3'd4: begin r = x - y; mC = (x < y); end
            3'd5: begin s = int'(x) + 1;         r = s[7:0]; mC = (s > 255); end
            3'd6: r = imm;
            default: begin s = int'(x) + int'(imm); r = s[7:0]; mC = (s > 255); end
        endcase
        if (ins[15:13] != 3'd2) mZ = (r == 8'h00);
        mRegs[ins[12:11]] = r;
        mRes = r;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic waitReady(input string tag, output bit ok);
        int waitCnt = 0;
        while (!instr_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        ok = instr_ready;
        if (!ok) checkOutput({tag, ".readyTimeout"}, 16'(instr_ready), 16'd1);
    endtask

    // Runs one instruction through the handshake; starts and ends at a falling edge in IDLE.
    task automatic applyStimulus(input logic [15:0] ins, input string tag);
        logic [7:0] ea;
        logic [7:0] eb;
        logic [4:0] eop;
        bit         ok;
        waitReady(tag, ok);
        if (!ok) return;
        instr       = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        expDrive(ins, ea, eb, eop);
        checkOutput({tag, ".execReady"}, 16'(instr_ready), 16'd0);
        checkOutput({tag, ".execResValid"}, 16'(res_valid), 16'd0);
        checkOutput({tag, ".aluOp"}, 16'(alu_op), 16'(eop));
        checkOutput({tag, ".aluA"}, 16'(alu_a), 16'(ea));
        checkOutput({tag, ".aluB"}, 16'(alu_b), 16'(eb));
        modelExec(ins);
        @(negedge clk);
        dbg_sel = ins[12:11];
        #1;
        gotRes = res_data;
        gotC   = flag_c;
        gotZ   = flag_z;
        checkOutput({tag, ".resValid"}, 16'(res_valid), 16'd1);
        checkOutput({tag, ".resData"}, 16'(res_data), 16'(mRes));
        checkOutput({tag, ".flagC"}, 16'(flag_c), 16'(mC));
        checkOutput({tag, ".flagZ"}, 16'(flag_z), 16'(mZ));
        checkOutput({tag, ".dbgRd"}, 16'(dbg_data), 16'(mRegs[ins[12:11]]));
        @(negedge clk);
        checkOutput({tag, ".idleReady"}, 16'(instr_ready), 16'd1);
        checkOutput({tag, ".idleResValid"}, 16'(res_valid), 16'd0);
        checkOutput({tag, ".idleAluOp"}, 16'(alu_op), 16'b00010);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] b2b [3];
        int          accCycle [3];
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [4:0]  eop;
        bit          ok;

        vecs[0]  = '{mk(3'd6, 2'd0, 2'd0, 8'h7F), 8'h7F, 1'b0, 1'b0};
        vecs[1]  = '{mk(3'd6, 2'd1, 2'd0, 8'h01), 8'h01, 1'b0, 1'b0};
        vecs[2]  = '{mk(3'd0, 2'd0, 2'd1, 8'h00), 8'h80, 1'b0, 1'b0};
        vecs[3]  = '{mk(3'd6, 2'd2, 2'd0, 8'hFF), 8'hFF, 1'b0, 1'b0};
        vecs[4]  = '{mk(3'd5, 2'd2, 2'd0, 8'h00), 8'h00, 1'b1, 1'b1};
        vecs[5]  = '{mk(3'd1, 2'd2, 2'd2, 8'h00), 8'h00, 1'b1, 1'b1};
        vecs[6]  = '{mk(3'd6, 2'd0, 2'd0, 8'h03), 8'h03, 1'b1, 1'b0};
        vecs[7]  = '{mk(3'd6, 2'd1, 2'd0, 8'h05), 8'h05, 1'b1, 1'b0};
        vecs[8]  = '{mk(3'd4, 2'd0, 2'd1, 8'h00), 8'hFE, 1'b1, 1'b0};
        vecs[9]  = '{mk(3'd4, 2'd1, 2'd1, 8'h00), 8'h00, 1'b0, 1'b1};
        vecs[10] = '{mk(3'd6, 2'd0, 2'd0, 8'h10), 8'h10, 1'b0, 1'b0};
        vecs[11] = '{mk(3'd2, 2'd1, 2'd0, 8'h00), 8'h00, 1'b0, 1'b0};
        vecs[12] = '{mk(3'd7, 2'd0, 2'd0, 8'hF5), 8'h05, 1'b1, 1'b0};
        vecs[13] = '{mk(3'd3, 2'd3, 2'd0, 8'h00), 8'h05, 1'b1, 1'b0};
        vecs[14] = '{mk(3'd2, 2'd1, 2'd0, 8'h00), 8'h00, 1'b1, 1'b0};

        rst_n       = 1'b0;
        instr       = mk(3'd6, 2'd0, 2'd0, 8'h55);
        instr_valid = 1'b1;
        dbg_sel     = 2'd0;
        modelReset();
        repeat (3) @(negedge clk);

        checkOutput("rst.ready", 16'(instr_ready), 16'd1);
        checkOutput("rst.resValid", 16'(res_valid), 16'd0);
        checkOutput("rst.resData", 16'(res_data), 16'h00);
        checkOutput("rst.flagC", 16'(flag_c), 16'd0);
        checkOutput("rst.flagZ", 16'(flag_z), 16'd0);
        checkOutput("rst.aluA", 16'(alu_a), 16'h00);
        checkOutput("rst.aluB", 16'(alu_b), 16'h00);
        checkOutput("rst.aluOp", 16'(alu_op), 16'b00010);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            checkOutput($sformatf("rst.reg%0d", i), 16'(dbg_data), 16'h00);
        end
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postRst.ready", 16'(instr_ready), 16'd1);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].ins, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d.tblRes", i), 16'(gotRes), 16'(vecs[i].expRes));
            checkOutput($sformatf("vec%0d.tblC", i), 16'(gotC), 16'(vecs[i].expC));
            checkOutput($sformatf("vec%0d.tblZ", i), 16'(gotZ), 16'(vecs[i].expZ));
        end
        dbg_sel = 2'd1;
        #1;
        checkOutput("nop.r1Kept", 16'(dbg_data), 16'h00);

        // Back-to-back: instr_valid never drops, so each accept must land exactly 3 cycles apart.
        b2b[0] = mk(3'd6, 2'd2, 2'd0, 8'h40);
        b2b[1] = mk(3'd7, 2'd2, 2'd0, 8'hC0);
        b2b[2] = mk(3'd4, 2'd3, 2'd2, 8'h00);
        instr       = b2b[0];
        instr_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            waitReady($sformatf("b2b%0d", j), ok);
            accCycle[j] = cycleCnt;
            @(negedge clk);
            expDrive(b2b[j], ea, eb, eop);
            checkOutput($sformatf("b2b%0d.aluOp", j), 16'(alu_op), 16'(eop));
            checkOutput($sformatf("b2b%0d.execReady", j), 16'(instr_ready), 16'd0);
            modelExec(b2b[j]);
            if (j < 2) instr = b2b[j+1];
            else instr_valid = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("b2b%0d.resValid", j), 16'(res_valid), 16'd1);
            checkOutput($sformatf("b2b%0d.resData", j), 16'(res_data), 16'(mRes));
            checkOutput($sformatf("b2b%0d.doneReady", j), 16'(instr_ready), 16'd0);
            @(negedge clk);
        end
        checkOutput("b2b.gap01", 16'(accCycle[1] - accCycle[0]), 16'd3);
        checkOutput("b2b.gap12", 16'(accCycle[2] - accCycle[1]), 16'd3);
        checkOutput("b2b.flagC", 16'(flag_c), 16'(mC));
        checkOutput("b2b.flagZ", 16'(flag_z), 16'(mZ));

        // Reset during EXEC of LDI r3,0xAA must drop the write and the completion pulse.
        waitReady("rstExec", ok);
        instr       = mk(3'd6, 2'd3, 2'd0, 8'hAA);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        checkOutput("rstExec.inExec", 16'(alu_op), 16'b00011);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rstExec.ready", 16'(instr_ready), 16'd1);
        checkOutput("rstExec.resValid", 16'(res_valid), 16'd0);
        @(negedge clk);
        checkOutput("rstExec.resValidHeld", 16'(res_valid), 16'd0);
        rst_n = 1'b1;
        modelReset();
        @(negedge clk);
        dbg_sel = 2'd3;
        #1;
        checkOutput("rstExec.r3", 16'(dbg_data), 16'h00);
        checkOutput("rstExec.readyAfter", 16'(instr_ready), 16'd1);
        checkOutput("rstExec.noPulse", 16'(res_valid), 16'd0);
        checkOutput("rstExec.flagC", 16'(flag_c), 16'd0);
        @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            logic [15:0] r;
            r = 16'($urandom);
            applyStimulus(r, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            checkOutput($sformatf("final.reg%0d", i), 16'(dbg_data), 16'(mRegs[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
